// File: rtl/config_bits_sync.sv
// config_bits_sync: brings static configuration bits into the user clock
// domain and offers them over valid/ready. Optional macro: CFG_PARITY_EN.
module config_bits_sync #(
    parameter int NoConfigBits = 12,
    parameter int StableCycles = 4
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [NoConfigBits-1:0] C_bits,
    input  logic                    ConfigDone,
    output logic [NoConfigBits-1:0] cfg_data,
    output logic                    cfg_valid,
    input  logic                    cfg_ready,
    output logic                    cfg_change
`ifdef CFG_PARITY_EN
    ,
    output logic                    cfg_parity
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    localparam logic [7:0] LAST_CNT = 8'(StableCycles - 1);

    logic [NoConfigBits-1:0] bits_m;
    logic [NoConfigBits-1:0] s_bits;
    logic                    done_m;
    logic                    s_done;
    logic [NoConfigBits-1:0] prev;
    logic [NoConfigBits-1:0] last;
    logic                    xfer_seen;

    logic [1:0] state;
    logic [1:0] state_n;
    logic [7:0] cnt;
    logic [7:0] cnt_n;
    logic       pending;
    logic       pending_n;
    logic       load;
    logic       stable;
    logic       differs;
    logic       xfer;

    assign stable    = (s_bits == prev);
    assign differs   = (s_bits != cfg_data);
    assign cfg_valid = (state == PRESENT);
    assign xfer      = cfg_valid & cfg_ready;

    // two-flop synchronizers for the asynchronous bits and done flag
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            bits_m <= '0;
            s_bits <= '0;
            done_m <= 1'b0;
            s_done <= 1'b0;
        end else begin
            bits_m <= C_bits;
            s_bits <= bits_m;
            done_m <= ConfigDone;
            s_done <= done_m;
        end
    end

    // one-cycle-old copy of the synchronized bits for stability detection
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= s_bits;
        end
    end

    // next-state, settle counter and pending-change decode
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pending_n = pending;
        load      = 1'b0;
        if (!s_done) begin
            state_n   = IDLE;
            cnt_n     = '0;
            pending_n = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt_n   = '0;
                    state_n = SETTLE;
                end
                SETTLE: begin
                    if (!stable) begin
                        cnt_n = '0;
                    end else if (cnt == LAST_CNT) begin
                        load    = 1'b1;
                        cnt_n   = '0;
                        state_n = PRESENT;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                PRESENT: begin
                    if (differs) begin
                        pending_n = 1'b1;
                    end
                    if (xfer) begin
                        state_n   = pending ? SETTLE : HOLD;
                        pending_n = 1'b0;
                        cnt_n     = '0;
                    end
                end
                HOLD: begin
                    if (differs) begin
                        cnt_n   = '0;
                        state_n = SETTLE;
                    end
                end
                default: begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    pending_n = 1'b0;
                end
            endcase
        end
    end

    // FSM state, counter and pending flag
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pending <= pending_n;
        end
    end

    // offered value, loaded only when entering PRESENT
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cfg_data <= '0;
        end else if (load) begin
            cfg_data <= s_bits;
        end
    end

`ifdef CFG_PARITY_EN
    // parity travels with cfg_data
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cfg_parity <= 1'b0;
        end else if (load) begin
            cfg_parity <= ^s_bits;
        end
    end
`endif

    // transfer history and change pulse; a transfer completes even on abort
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            last       <= '0;
            xfer_seen  <= 1'b0;
            cfg_change <= 1'b0;
        end else begin
            cfg_change <= xfer & (~xfer_seen | (cfg_data != last));
            if (xfer) begin
                last      <= cfg_data;
                xfer_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_config_bits_sync.sv
// tb_config_bits_sync: directed timing scenarios plus randomized traffic
// checked against a transaction-level model of config_bits_sync.
module tb_config_bits_sync;

    localparam int W = 12;
    localparam int S = 4;

    logic         CLK = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] C_bits = '0;
    logic         ConfigDone = 1'b0;
    logic [W-1:0] cfg_data;
    logic         cfg_valid;
    logic         cfg_ready = 1'b0;
    logic         cfg_change;
    logic         cfg_parity;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] hist[$];
    logic         dhist[$];

    config_bits_sync #(
        .NoConfigBits(W),
        .StableCycles(S)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .C_bits    (C_bits),
        .ConfigDone(ConfigDone),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_change(cfg_change)
`ifdef CFG_PARITY_EN
        ,
        .cfg_parity(cfg_parity)
`endif
    );

`ifndef CFG_PARITY_EN
    assign cfg_parity = 1'b0;
`endif

    always #5 CLK = ~CLK;

    // input history indexed by edge number
    always @(posedge CLK) begin
        hist.push_back(C_bits);
        dhist.push_back(ConfigDone);
    end

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (cfg_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        C_bits = '0;
        ConfigDone = 1'b0;
        cfg_ready = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({cfg_data, cfg_valid, cfg_change, cfg_parity} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got %h/%b/%b exp 0/0/0",
                     cfg_data, cfg_valid, cfg_change);
        end
        reset = 1'b0;
        C_bits = 12'hA5C;
        ConfigDone = 1'b1;
        cfg_ready = 1'b1;
        for (int e = 1; e <= 3 + S; e++) begin
            tick();
            if (e == 2 + S) begin
                n_tests++;
                if (cfg_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL latency_early got %b exp 0", cfg_valid);
                end
            end
        end
        n_tests++;
        if (cfg_valid !== 1'b1 || cfg_data !== 12'hA5C) begin
            n_fail++;
            $display("FAIL latency_offer got %b/%h exp 1/a5c",
                     cfg_valid, cfg_data);
        end
        tick();
        n_tests++;
        if (cfg_change !== 1'b1 || cfg_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_change got chg %b vld %b exp 1/0",
                     cfg_change, cfg_valid);
        end
    endtask

    task automatic test_glitch();
        bit quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) C_bits = (i % 4 == 0) ? 12'hA54 : 12'hA5C;
            tick();
            if (cfg_valid !== 1'b0) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL glitch_quiet got valid 1 exp 0");
        end
        C_bits = 12'h123;
        for (int e = 1; e <= 3 + S; e++) begin
            tick();
            if (e == 2 + S) begin
                n_tests++;
                if (cfg_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL glitch_early got %b exp 0", cfg_valid);
                end
            end
        end
        n_tests++;
        if (cfg_valid !== 1'b1 || cfg_data !== 12'h123) begin
            n_fail++;
            $display("FAIL glitch_offer got %b/%h exp 1/123",
                     cfg_valid, cfg_data);
        end
        tick();
        n_tests++;
        if (cfg_change !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_change got %b exp 1", cfg_change);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit held = 1'b1;
        int k;
        cfg_ready = 1'b0;
        C_bits = 12'h0F0;
        wait_valid(20, ok);
        n_tests++;
        if (!ok || cfg_data !== 12'h0F0) begin
            n_fail++;
            $display("FAIL bp_offer got %b/%h exp 1/0f0", ok, cfg_data);
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) C_bits = 12'h00F;
            tick();
            if (cfg_valid !== 1'b1 || cfg_data !== 12'h0F0) held = 1'b0;
        end
        n_tests++;
        if (!held) begin
            n_fail++;
            $display("FAIL bp_hold got %b/%h exp 1/0f0", cfg_valid, cfg_data);
        end
        cfg_ready = 1'b1;
        tick();
        n_tests++;
        if (cfg_change !== 1'b1 || cfg_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_xfer1 got chg %b vld %b exp 1/0",
                     cfg_change, cfg_valid);
        end
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (cfg_valid === 1'b1) begin
                k = i;
                break;
            end
        end
        n_tests++;
        if (k + 1 < S + 1 || cfg_data !== 12'h00F) begin
            n_fail++;
            $display("FAIL bp_reoffer got gap %0d data %h exp >=%0d/00f",
                     k + 1, cfg_data, S + 1);
        end
        tick();
        n_tests++;
        if (cfg_change !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_xfer2 got %b exp 1", cfg_change);
        end
    endtask

    task automatic test_same_value();
        bit ok;
        cfg_ready = 1'b1;
        C_bits = 12'h7FF;
        wait_valid(20, ok);
        tick();
        n_tests++;
        if (!ok || cfg_change !== 1'b1) begin
            n_fail++;
            $display("FAIL same_first got %b/%b exp 1/1", ok, cfg_change);
        end
        ConfigDone = 1'b0;
        repeat (5) tick();
        ConfigDone = 1'b1;
        wait_valid(20, ok);
        n_tests++;
        if (!ok || cfg_data !== 12'h7FF) begin
            n_fail++;
            $display("FAIL same_offer got %b/%h exp 1/7ff", ok, cfg_data);
        end
        tick();
        n_tests++;
        if (cfg_change !== 1'b0 || cfg_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL same_change got chg %b vld %b exp 0/0",
                     cfg_change, cfg_valid);
        end
    endtask

`ifdef CFG_PARITY_EN
    task automatic test_parity();
        bit ok;
        cfg_ready = 1'b1;
        C_bits = 12'h001;
        wait_valid(20, ok);
        n_tests++;
        if (!ok || cfg_data !== 12'h001 || cfg_parity !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_odd got %b/%h/%b exp 1/001/1",
                     ok, cfg_data, cfg_parity);
        end
        tick();
        C_bits = 12'h003;
        wait_valid(20, ok);
        n_tests++;
        if (!ok || cfg_data !== 12'h003 || cfg_parity !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_even got %b/%h/%b exp 1/003/0",
                     ok, cfg_data, cfg_parity);
        end
        tick();
    endtask
`endif

    task automatic test_abort();
        bit ok;
        cfg_ready = 1'b0;
        C_bits = 12'h3C3;
        wait_valid(20, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL abort_offer got 0 exp 1");
        end
        ConfigDone = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (cfg_valid !== 1'b0 || cfg_data !== 12'h3C3) begin
            n_fail++;
            $display("FAIL abort_drop got %b/%h exp 0/3c3",
                     cfg_valid, cfg_data);
        end
        ConfigDone = 1'b1;
        C_bits = 12'h555;
        repeat (4) tick();
        #3;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({cfg_data, cfg_valid, cfg_change, cfg_parity} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got %h/%b/%b exp 0/0/0",
                     cfg_data, cfg_valid, cfg_change);
        end
        @(posedge CLK);
        #1;
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_random();
        logic [W-1:0] pool[4];
        logic [W-1:0] m_last = '0;
        logic [W-1:0] prev_data;
        bit           m_have = 1'b0;
        bit           exp_chg = 1'b0;
        bit           prev_valid;
        bit           xfer_prev = 1'b0;
        bit           xfer;
        bit           win_ok;
        int           hold_left = 0;
        int           done_low = 0;
        int           L;
        pool[0] = 12'h000;
        pool[1] = 12'hFFF;
        pool[2] = $urandom_range(0, 4095);
        pool[3] = $urandom_range(0, 4095);
        prev_valid = cfg_valid;
        prev_data  = cfg_data;
        for (int c = 0; c < 800; c++) begin
            L = hist.size() - 1;
            n_tests++;
            if (cfg_change !== exp_chg) begin
                n_fail++;
                $display("FAIL rnd_change cyc %0d got %b exp %b",
                         c, cfg_change, exp_chg);
            end
            if (xfer_prev) begin
                n_tests++;
                if (cfg_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_post_xfer cyc %0d got 1 exp 0", c);
                end
            end else if (prev_valid) begin
                n_tests++;
                if (cfg_valid === 1'b1 && cfg_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL rnd_data_hold cyc %0d got %h exp %h",
                             c, cfg_data, prev_data);
                end else if (cfg_valid !== 1'b1 && dhist[L-2] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_withdraw cyc %0d got 0 exp 1", c);
                end
            end
            if (cfg_valid === 1'b1 && !prev_valid && L - 2 - S >= 0) begin
                win_ok = 1'b1;
                for (int j = L - 2 - S; j <= L - 2; j++) begin
                    if (hist[j] !== cfg_data) win_ok = 1'b0;
                end
                n_tests++;
                if (!win_ok) begin
                    n_fail++;
                    $display("FAIL rnd_settled cyc %0d got %h exp %h",
                             c, cfg_data, hist[L-2]);
                end
            end
`ifdef CFG_PARITY_EN
            if (cfg_valid === 1'b1) begin
                n_tests++;
                if (cfg_parity !== ^cfg_data) begin
                    n_fail++;
                    $display("FAIL rnd_parity cyc %0d got %b exp %b",
                             c, cfg_parity, ^cfg_data);
                end
            end
`endif
            cfg_ready = ($urandom_range(0, 2) != 0);
            if (hold_left == 0) begin
                C_bits = pool[$urandom_range(0, 3)];
                hold_left = $urandom_range(1, 12);
            end else begin
                hold_left--;
            end
            if (done_low > 0) begin
                done_low--;
                ConfigDone = (done_low != 0) ? 1'b0 : 1'b1;
            end else if ($urandom_range(0, 39) == 0) begin
                done_low = $urandom_range(2, 6);
                ConfigDone = 1'b0;
            end
            xfer = (cfg_valid === 1'b1) && cfg_ready;
            exp_chg = xfer && (!m_have || cfg_data != m_last);
            if (xfer) begin
                m_have = 1'b1;
                m_last = cfg_data;
            end
            prev_valid = cfg_valid;
            prev_data  = cfg_data;
            xfer_prev  = xfer;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_backpressure();
        test_same_value();
`ifdef CFG_PARITY_EN
        test_parity();
`endif
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
